mem_port_arbiter: RTL

- Shares the single unified instruction/data memory between two requesters.
- Port 0 is the multicycle CPU (fetch plus load/store). Port 1 is a secondary master, such as a program loader or DMA.
- Serialises accesses using round-robin arbitration and a fixed-latency memory sequencer.
- Requesters use a level req / pulse ready handshake. The memory side sees one access at a time.

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and memory-side signals for mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requester/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ready;
  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ready;
  logic [DATA_W-1:0] rdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              owner;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_ready, p1_ready, rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    output busy, owner
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_ready, p1_ready, rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    input  busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter with a fixed-latency memory sequencer.
// Define MEM_ARB_CPU_PRIO_EN to make port 0 win every tie (fixed priority).
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [3:0]        lat_cnt_q, lat_cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              grant_s;
  logic              win_s;

  always_comb begin
    grant_s = 1'b0;
    win_s   = 1'b0;
    if (bus.p0_req && bus.p1_req) begin
      grant_s = 1'b1;
`ifdef MEM_ARB_CPU_PRIO_EN
      win_s   = 1'b0;
`else
      win_s   = ~last_grant_q;
`endif
    end else if (bus.p0_req) begin
      grant_s = 1'b1;
      win_s   = 1'b0;
    end else if (bus.p1_req) begin
      grant_s = 1'b1;
      win_s   = 1'b1;
    end else begin
      grant_s = 1'b0;
      win_s   = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_s) begin
          owner_d      = win_s;
          last_grant_d = win_s;
          we_d         = win_s ? bus.p1_we    : bus.p0_we;
          addr_d       = win_s ? bus.p1_addr  : bus.p0_addr;
          wdata_d      = win_s ? bus.p1_wdata : bus.p0_wdata;
          lat_cnt_d    = LAT_INIT;
          state_d      = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (lat_cnt_q == 4'd0) begin
          // Memory data is sampled on the last strobe cycle only.
          if (!we_q) begin
            rdata_d = bus.mem_rdata;
          end else begin
            rdata_d = rdata_q;
          end
          state_d = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      lat_cnt_q    <= 4'd0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // Everything below decodes registers only, so an async reset clears strobes at once.
  assign bus.mem_rd    = (state_q == BUSY) && !we_q;
  assign bus.mem_wr    = (state_q == BUSY) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.p0_ready  = (state_q == RESP) && !owner_q;
  assign bus.p1_ready  = (state_q == RESP) && owner_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.owner     = owner_q;

endmodule
